// File: rtl/mvm_loader_pkg.sv
// Shared types and helpers for the MVM stream loader.
// Optional checksum frame byte is enabled by defining LOADER_CHECKSUM_EN.
package mvm_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_X = 3'd1,
        S_LOAD_A = 3'd2,
        S_CHECK  = 3'd3,
        S_START  = 3'd4,
        S_WAIT   = 3'd5,
        S_DRAIN  = 3'd6
    } state_t;

    localparam int CHK_W = 8;

    // Ceiling log2, never narrower than one bit so address ports stay legal.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/mvm_stream_loader_if.sv
// X/A block-RAM write port bundle driven by the stream loader.
// Widths follow DATA_W and MAX_N; LOADER_CHECKSUM_EN has no effect here.
interface mvm_stream_loader_if
    import mvm_loader_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int MAX_N  = 64
);

    localparam int X_ADDR_W = clog2(MAX_N);
    localparam int A_ADDR_W = clog2(MAX_N * MAX_N);

    logic                X_Ena_out;
    logic                X_Wena_out;
    logic [DATA_W-1:0]   X_Dina_out;
    logic [X_ADDR_W-1:0] X_Addra_out;
    logic                A_Ena_out;
    logic                A_Wena_out;
    logic [DATA_W-1:0]   A_Dina_out;
    logic [A_ADDR_W-1:0] A_Addra_out;

    modport master (
        output X_Ena_out, X_Wena_out, X_Dina_out, X_Addra_out,
        output A_Ena_out, A_Wena_out, A_Dina_out, A_Addra_out
    );

    modport slave (
        input X_Ena_out, X_Wena_out, X_Dina_out, X_Addra_out,
        input A_Ena_out, A_Wena_out, A_Dina_out, A_Addra_out
    );

endinterface

// File: rtl/byte_packer.sv
// Little-endian byte-to-word packer with a one-cycle word_valid strobe.
// Unaffected by LOADER_CHECKSUM_EN.
module byte_packer #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic [7:0]        byte_in,
    input  logic              valid_in,
    output logic              last_out,
    output logic [DATA_W-1:0] word_out,
    output logic              word_valid_out
);

    localparam int BPW = DATA_W / 8;
    localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;

    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic              wv_q, wv_d;
    logic              last;

    // Byte lane insertion and word completion.
    always_comb begin
        cnt_d  = cnt_q;
        acc_d  = acc_q;
        word_d = word_q;
        wv_d   = 1'b0;
        last   = valid_in && !clr && (cnt_q == CW'(BPW - 1));
        if (clr) begin
            cnt_d = '0;
            acc_d = '0;
        end else if (valid_in) begin
            for (int k = 0; k < BPW; k++) begin
                if (cnt_q == CW'(k)) acc_d[8*k +: 8] = byte_in;
            end
            if (last) begin
                cnt_d  = '0;
                word_d = acc_d;
                wv_d   = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Packer state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            acc_q  <= '0;
            word_q <= '0;
            wv_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
            word_q <= word_d;
            wv_q   <= wv_d;
        end
    end

    assign last_out       = last;
    assign word_out       = word_q;
    assign word_valid_out = wv_q;

endmodule

// File: rtl/mvm_stream_loader.sv
// Framed UART stream parser loading X and A RAMs, then starting the MVM core.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module mvm_stream_loader
    import mvm_loader_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int MAX_N      = 64,
    parameter int GAP_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       RST,
    input  logic [7:0] Rx_Byte_in,
    input  logic       Rx_DV_in,
    input  logic       Done_in,
    mvm_stream_loader_if.master ram,
    output logic [7:0] N_out,
    output logic       N_valid_out,
    output logic       Load_out,
    output logic       Start_out,
    output logic       Busy_out,
    output logic       Err_out,
    output logic       Overrun_out
);

    localparam int X_ADDR_W = clog2(MAX_N);
    localparam int A_ADDR_W = clog2(MAX_N * MAX_N);

    state_t              state_q, state_d;
    logic [7:0]          n_q, n_d;
    logic                nv_q, nv_d;
    logic                err_q, err_d;
    logic [15:0]         nn_q, nn_d;
    logic [7:0]          x_idx_q, x_idx_d;
    logic [15:0]         a_idx_q, a_idx_d;
    logic                tgt_x_q, tgt_x_d;
    logic [X_ADDR_W-1:0] x_addr_q, x_addr_d;
    logic [A_ADDR_W-1:0] a_addr_q, a_addr_d;
    logic                start_q, start_d;
    logic                ovr_q, ovr_d;
    logic [31:0]         gap_q, gap_d;
`ifdef LOADER_CHECKSUM_EN
    logic [CHK_W-1:0]    chk_q, chk_d;
`endif

    logic              pk_clr;
    logic              pk_vld;
    logic              pk_last;
    logic [DATA_W-1:0] pk_word;
    logic              pk_wv;

    byte_packer #(.DATA_W(DATA_W)) u_packer (
        .clk            (clk),
        .rst            (RST),
        .clr            (pk_clr),
        .byte_in        (Rx_Byte_in),
        .valid_in       (pk_vld),
        .last_out       (pk_last),
        .word_out       (pk_word),
        .word_valid_out (pk_wv)
    );

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (RST) begin
            state_q  <= S_IDLE;
            n_q      <= '0;
            nv_q     <= 1'b0;
            err_q    <= 1'b0;
            nn_q     <= '0;
            x_idx_q  <= '0;
            a_idx_q  <= '0;
            tgt_x_q  <= 1'b0;
            x_addr_q <= '0;
            a_addr_q <= '0;
            start_q  <= 1'b0;
            ovr_q    <= 1'b0;
            gap_q    <= '0;
`ifdef LOADER_CHECKSUM_EN
            chk_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            nv_q     <= nv_d;
            err_q    <= err_d;
            nn_q     <= nn_d;
            x_idx_q  <= x_idx_d;
            a_idx_q  <= a_idx_d;
            tgt_x_q  <= tgt_x_d;
            x_addr_q <= x_addr_d;
            a_addr_q <= a_addr_d;
            start_q  <= start_d;
            ovr_q    <= ovr_d;
            gap_q    <= gap_d;
`ifdef LOADER_CHECKSUM_EN
            chk_q    <= chk_d;
`endif
        end
    end

    // Frame parsing: next state, counters and word address capture.
    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        nv_d     = nv_q;
        err_d    = err_q;
        nn_d     = nn_q;
        x_idx_d  = x_idx_q;
        a_idx_d  = a_idx_q;
        tgt_x_d  = tgt_x_q;
        x_addr_d = x_addr_q;
        a_addr_d = a_addr_q;
        start_d  = 1'b0;
        ovr_d    = 1'b0;
        gap_d    = gap_q;
        pk_clr   = 1'b0;
        pk_vld   = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        chk_d    = chk_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (Rx_DV_in) begin
                    if (Rx_Byte_in != 8'd0 && 32'(Rx_Byte_in) <= 32'(MAX_N)) begin
                        n_d     = Rx_Byte_in;
                        nv_d    = 1'b1;
                        err_d   = 1'b0;
                        nn_d    = {8'd0, Rx_Byte_in} * {8'd0, Rx_Byte_in};
                        x_idx_d = '0;
                        a_idx_d = '0;
                        pk_clr  = 1'b1;
                        state_d = S_LOAD_X;
`ifdef LOADER_CHECKSUM_EN
                        chk_d   = Rx_Byte_in;
`endif
                    end else begin
                        err_d   = 1'b1;
                        nv_d    = 1'b0;
                        gap_d   = '0;
                        state_d = S_DRAIN;
                    end
                end
            end
            S_LOAD_X: begin
                pk_vld = Rx_DV_in;
`ifdef LOADER_CHECKSUM_EN
                if (Rx_DV_in) chk_d = chk_q ^ Rx_Byte_in;
`endif
                if (pk_last) begin
                    tgt_x_d  = 1'b1;
                    x_addr_d = x_idx_q[X_ADDR_W-1:0];
                    if (x_idx_q == n_q - 8'd1) state_d = S_LOAD_A;
                    else x_idx_d = x_idx_q + 8'd1;
                end
            end
            S_LOAD_A: begin
                pk_vld = Rx_DV_in;
`ifdef LOADER_CHECKSUM_EN
                if (Rx_DV_in) chk_d = chk_q ^ Rx_Byte_in;
`endif
                if (pk_last) begin
                    tgt_x_d  = 1'b0;
                    a_addr_d = a_idx_q[A_ADDR_W-1:0];
                    if (a_idx_q == nn_q - 16'd1) begin
`ifdef LOADER_CHECKSUM_EN
                        state_d = S_CHECK;
`else
                        state_d = S_START;
`endif
                    end else begin
                        a_idx_d = a_idx_q + 16'd1;
                    end
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (Rx_DV_in) begin
                    if (Rx_Byte_in == chk_q) begin
                        state_d = S_START;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
`endif
            S_START: begin
                start_d = 1'b1;
                ovr_d   = Rx_DV_in;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                ovr_d = Rx_DV_in;
                if (Done_in) state_d = S_IDLE;
            end
            S_DRAIN: begin
                if (Rx_DV_in) gap_d = '0;
                else if (gap_q == 32'(GAP_CYCLES - 1)) state_d = S_IDLE;
                else gap_d = gap_q + 32'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode: RAM strobes follow the packer's registered word.
    always_comb begin
        ram.X_Ena_out   = pk_wv && tgt_x_q;
        ram.X_Wena_out  = pk_wv && tgt_x_q;
        ram.X_Dina_out  = pk_word;
        ram.X_Addra_out = x_addr_q;
        ram.A_Ena_out   = pk_wv && !tgt_x_q;
        ram.A_Wena_out  = pk_wv && !tgt_x_q;
        ram.A_Dina_out  = pk_word;
        ram.A_Addra_out = a_addr_q;
        N_out           = n_q;
        N_valid_out     = nv_q;
        Load_out        = (state_q == S_LOAD_X) || (state_q == S_LOAD_A);
        Start_out       = start_q;
        Busy_out        = (state_q != S_IDLE);
        Err_out         = err_q;
        Overrun_out     = ovr_q;
    end

endmodule

// File: tb/tb_mvm_stream_loader.sv
// Scoreboard bench for mvm_stream_loader (DATA_W=32, MAX_N=64).
// Appends checksum bytes when LOADER_CHECKSUM_EN is defined.
module tb_mvm_stream_loader;

    localparam int DW   = 32;
    localparam int MAXN = 64;
    localparam int GAP  = 64;
    localparam int BPW  = DW / 8;

    typedef struct {
        int          addr;
        logic [31:0] data;
        bit          last;
    } wr_t;

    logic       clk = 1'b0;
    logic       RST;
    logic [7:0] rx_byte;
    logic       rx_dv;
    logic       done;
    logic [7:0] n_out;
    logic       n_valid, load, start, busy, err, ovr;

    mvm_stream_loader_if #(.DATA_W(DW), .MAX_N(MAXN)) ram_if ();

    mvm_stream_loader #(
        .DATA_W     (DW),
        .MAX_N      (MAXN),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk         (clk),
        .RST         (RST),
        .Rx_Byte_in  (rx_byte),
        .Rx_DV_in    (rx_dv),
        .Done_in     (done),
        .ram         (ram_if.master),
        .N_out       (n_out),
        .N_valid_out (n_valid),
        .Load_out    (load),
        .Start_out   (start),
        .Busy_out    (busy),
        .Err_out     (err),
        .Overrun_out (ovr)
    );

    always #5 clk = ~clk;

    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;
    longint last_a_cyc = -10;
    int     start_exp = 0;
    int     start_cnt = 0;
    int     ovr_cnt = 0;
    wr_t    xq[$];
    wr_t    aq[$];
    logic [31:0] fx[$];
    logic [31:0] fa[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Monitor: pops expected writes and checks Start timing.
    always @(negedge clk) begin
        wr_t e;
        if (ram_if.X_Ena_out) begin
            checks++;
            if (xq.size() == 0) begin
                errors++;
                $display("FAIL x_unexpected: addr %0d data %h, want no write",
                         ram_if.X_Addra_out, ram_if.X_Dina_out);
            end else begin
                e = xq.pop_front();
                if (32'(ram_if.X_Addra_out) !== e.addr || ram_if.X_Dina_out !== e.data ||
                    ram_if.X_Wena_out !== 1'b1) begin
                    errors++;
                    $display("FAIL x_write: got addr %0d data %h we %b, want addr %0d data %h",
                             ram_if.X_Addra_out, ram_if.X_Dina_out, ram_if.X_Wena_out,
                             e.addr, e.data);
                end
            end
        end
        if (ram_if.A_Ena_out) begin
            checks++;
            if (aq.size() == 0) begin
                errors++;
                $display("FAIL a_unexpected: addr %0d data %h, want no write",
                         ram_if.A_Addra_out, ram_if.A_Dina_out);
            end else begin
                e = aq.pop_front();
                if (e.last) last_a_cyc = cyc;
                if (32'(ram_if.A_Addra_out) !== e.addr || ram_if.A_Dina_out !== e.data ||
                    ram_if.A_Wena_out !== 1'b1) begin
                    errors++;
                    $display("FAIL a_write: got addr %0d data %h we %b, want addr %0d data %h",
                             ram_if.A_Addra_out, ram_if.A_Dina_out, ram_if.A_Wena_out,
                             e.addr, e.data);
                end
            end
        end
        if (start) begin
            checks++;
            start_cnt++;
`ifdef LOADER_CHECKSUM_EN
            if (start_exp == 0 || cyc <= last_a_cyc) begin
`else
            if (start_exp == 0 || cyc != last_a_cyc + 1) begin
`endif
                errors++;
                $display("FAIL start_timing: start at cycle %0d, last A strobe %0d, pending %0d",
                         cyc, last_a_cyc, start_exp);
            end else begin
                start_exp--;
            end
        end
        if (ovr) ovr_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_byte = b;
        rx_dv   = 1'b1;
        @(posedge clk);
        #1;
        rx_dv   = 1'b0;
    endtask

    task automatic gap(input int gmax);
        if (gmax > 0) tick($urandom_range(0, gmax));
    endtask

    task automatic fill(input int n);
        fx.delete();
        fa.delete();
        for (int i = 0; i < n; i++) fx.push_back($urandom);
        for (int i = 0; i < n * n; i++) fa.push_back($urandom);
    endtask

    // Byte stream of one frame; expected writes are queued first.
    task automatic send_body(input int n, input int gmax, input int a_words,
                             output logic [7:0] chk);
        logic [31:0] w;
        chk = 8'(n);
        send_byte(8'(n));
        for (int i = 0; i < n; i++) begin
            w = fx[i];
            for (int k = 0; k < BPW; k++) begin
                gap(gmax);
                send_byte(w[8*k +: 8]);
                chk = chk ^ w[8*k +: 8];
            end
        end
        for (int i = 0; i < a_words; i++) begin
            w = fa[i];
            for (int k = 0; k < BPW; k++) begin
                gap(gmax);
                send_byte(w[8*k +: 8]);
                chk = chk ^ w[8*k +: 8];
            end
        end
    endtask

    task automatic push_exp(input int n);
        for (int i = 0; i < n; i++) xq.push_back('{addr: i, data: fx[i], last: 1'b0});
        for (int r = 0; r < n; r++) begin
            for (int c = 0; c < n; c++) begin
                aq.push_back('{addr: r * n + c, data: fa[r * n + c],
                               last: (r == n - 1) && (c == n - 1)});
            end
        end
    endtask

    task automatic run_frame(input int n, input int gmax, input int ovr_bytes);
        logic [7:0] chk;
        int s0, o0, t;
        push_exp(n);
        start_exp++;
        s0 = start_cnt;
        send_body(n, gmax, n * n, chk);
`ifdef LOADER_CHECKSUM_EN
        gap(gmax);
        send_byte(chk);
`endif
        t = 0;
        while (start_cnt == s0 && t < 200) begin
            tick(1);
            t++;
        end
        check($sformatf("start_seen_n%0d", n), 64'(start_cnt - s0), 64'd1);
        check("busy_wait", 64'(busy), 64'd1);
        check("n_out", 64'(n_out), 64'(n));
        check("n_valid", 64'(n_valid), 64'd1);
        check("err_clear", 64'(err), 64'd0);
        check("load_low", 64'(load), 64'd0);
        if (ovr_bytes > 0) begin
            o0 = ovr_cnt;
            for (int i = 0; i < ovr_bytes; i++) begin
                send_byte(8'($urandom));
                tick(1);
            end
            tick(2);
            check("overrun_count", 64'(ovr_cnt - o0), 64'(ovr_bytes));
        end
        done = 1'b1;
        tick(1);
        done = 1'b0;
        check("busy_after_done", 64'(busy), 64'd0);
        check("n_valid_held", 64'(n_valid), 64'd1);
        check("x_queue_empty", 64'(xq.size()), 64'd0);
        check("a_queue_empty", 64'(aq.size()), 64'd0);
    endtask

    initial begin
        logic [7:0] chk;
        RST     = 1'b1;
        rx_dv   = 1'b0;
        rx_byte = 8'd0;
        done    = 1'b0;
        tick(3);
        check("rst_n_out", 64'(n_out), 64'd0);
        check("rst_n_valid", 64'(n_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_start", 64'(start), 64'd0);
        check("rst_x_ena", 64'(ram_if.X_Ena_out), 64'd0);
        check("rst_a_ena", 64'(ram_if.A_Ena_out), 64'd0);
        check("rst_dina", 64'(ram_if.X_Dina_out), 64'd0);
        RST = 1'b0;
        tick(2);

        fx = '{32'h11223344, 32'h55667788};
        fa = '{32'd1, 32'd2, 32'd3, 32'd4};
        run_frame(2, 2, 3);

        send_byte(8'h00);
        check("bad_hdr0_err", 64'(err), 64'd1);
        check("bad_hdr0_busy", 64'(busy), 64'd1);
        check("bad_hdr0_nvalid", 64'(n_valid), 64'd0);
        tick(GAP + 8);
        check("drain_done_busy", 64'(busy), 64'd0);
        send_byte(8'h50);
        check("bad_hdr50_err", 64'(err), 64'd1);
        tick(GAP / 2);
        check("drain_mid_busy", 64'(busy), 64'd1);
        tick(GAP);
        check("drain_end_busy", 64'(busy), 64'd0);
        check("err_sticky", 64'(err), 64'd1);
        fill(1);
        run_frame(1, 1, 0);

        for (int f = 0; f < 6; f++) begin
            int n;
            n = $urandom_range(1, 5);
            fill(n);
            run_frame(n, (f % 2 == 0) ? 0 : 3, f % 3);
        end

        fill(MAXN);
        run_frame(MAXN, 0, 0);

        fill(3);
        push_exp(3);
        send_body(3, 0, 1, chk);
        send_byte(8'hA5);
        check("mid_a_load", 64'(load), 64'd1);
        RST = 1'b1;
        tick(1);
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_load", 64'(load), 64'd0);
        check("rst_mid_nvalid", 64'(n_valid), 64'd0);
        check("rst_mid_n", 64'(n_out), 64'd0);
        check("rst_mid_a_ena", 64'(ram_if.A_Ena_out), 64'd0);
        check("rst_mid_x_q_drained", 64'(xq.size()), 64'd0);
        xq.delete();
        aq.delete();
        RST = 1'b0;
        tick(2);
        fill(1);
        run_frame(1, 0, 0);

`ifdef LOADER_CHECKSUM_EN
        begin
            int s0;
            fill(1);
            push_exp(1);
            s0 = start_cnt;
            send_body(1, 0, 1, chk);
            send_byte(~chk);
            tick(4);
            check("bad_chk_err", 64'(err), 64'd1);
            check("bad_chk_busy", 64'(busy), 64'd0);
            check("bad_chk_nostart", 64'(start_cnt - s0), 64'd0);
            check("bad_chk_a_empty", 64'(aq.size()), 64'd0);
        end
`endif

        tick(5);
        check("final_start_pending", 64'(start_exp), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
